// File: rtl/mem_arbiter_rr_if.sv
// Requester/RAM bundle for mem_arbiter_rr: the arbiter uses the master modport,
// the requesters and RAM use the slave modport.
interface mem_arbiter_rr_if #(
  parameter int NUM_CH     = 2,
  parameter int MAX_BYTES  = 8,
  parameter int ADDR_WIDTH = 32
);
  localparam int LEN_W = $clog2(MAX_BYTES) + 1;

  logic [7:0]                    ram_din;
  logic                          io_buffer_full;
  logic [7:0]                    ram_dout;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic                          ram_wr;
  logic [NUM_CH-1:0]             ch_en;
  logic [NUM_CH-1:0]             ch_wr;
  logic [NUM_CH*LEN_W-1:0]       ch_len;
  logic [NUM_CH*ADDR_WIDTH-1:0]  ch_addr;
  logic [NUM_CH*8*MAX_BYTES-1:0] ch_wdata;
  logic [NUM_CH-1:0]             ch_done;
  logic [8*MAX_BYTES-1:0]        rdata;

  modport master (
    input  ram_din, io_buffer_full, ch_en, ch_wr, ch_len, ch_addr, ch_wdata,
    output ram_dout, ram_addr, ram_wr, ch_done, rdata
  );

  modport slave (
    output ram_din, io_buffer_full, ch_en, ch_wr, ch_len, ch_addr, ch_wdata,
    input  ram_dout, ram_addr, ram_wr, ch_done, rdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter serialising multi-byte channel reads/writes onto a byte-wide RAM port.
// Optional macro MEM_ARB_IO_STALL_EN: back-pressure transfers to the UART window while io_buffer_full.
module mem_arbiter_rr #(
  parameter int          NUM_CH     = 2,
  parameter int          MAX_BYTES  = 8,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = 32'h30000
) (
  input  logic             Sys_clk,
  input  logic             Sys_rst_n,
  input  logic             Sys_rdy,
  mem_arbiter_rr_if.master bus
);
  localparam int LEN_W  = $clog2(MAX_BYTES) + 1;
  localparam int PTR_W  = $clog2(NUM_CH);
  localparam int DATA_W = 8 * MAX_BYTES;
`ifdef MEM_ARB_IO_STALL_EN
  localparam logic IO_STALL_EN = 1'b1;
`else
  localparam logic IO_STALL_EN = 1'b0;
`endif
  localparam logic [ADDR_WIDTH-1:0] IO_LO  = ADDR_WIDTH'(IO_BASE);
  localparam logic [PTR_W:0]        NCH_LP = (PTR_W+1)'(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  function automatic logic in_io_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - IO_LO;
    return (off < ADDR_WIDTH'(8));
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == {LEN_W{1'b0}}) begin
      return LEN_W'(1);
    end else if (l > LEN_W'(MAX_BYTES)) begin
      return LEN_W'(MAX_BYTES);
    end else begin
      return l;
    end
  endfunction

  state_e                state_q,    state_d;
  logic [PTR_W-1:0]      rr_ptr_q,   rr_ptr_d;
  logic [PTR_W-1:0]      ch_q,       ch_d;
  logic [LEN_W-1:0]      len_q,      len_d;
  logic [LEN_W-1:0]      cnt_q,      cnt_d;
  logic [DATA_W-1:0]     wdata_q,    wdata_d;
  logic [DATA_W-1:0]     rbuf_q,     rbuf_d;
  logic [DATA_W-1:0]     rdata_q,    rdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q,   ram_wr_d;
  logic [NUM_CH-1:0]     ch_done_q,  ch_done_d;

  logic [NUM_CH-1:0]     elig_s;
  logic [NUM_CH-1:0]     rot_s;
  logic                  gnt_valid_s;
  logic [PTR_W-1:0]      gnt_idx_s;
  logic                  sel_wr_s;
  logic [LEN_W-1:0]      sel_len_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_W-1:0]     sel_wdata_s;
  logic                  stall_s;

  // Eligibility: requesting, not completing this cycle, not blocked by a full UART.
  always_comb begin
    elig_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      elig_s[i] = bus.ch_en[i] & ~ch_done_q[i] &
                  ~(IO_STALL_EN & bus.io_buffer_full &
                    in_io_window(bus.ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH]));
    end
  end

  // Rotate so bit k is channel rr_ptr+k, then take the lowest set bit.
  always_comb begin
    rot_s       = (elig_s >> rr_ptr_q) | (elig_s << (NCH_LP - {1'b0, rr_ptr_q}));
    gnt_valid_s = 1'b0;
    gnt_idx_s   = {PTR_W{1'b0}};
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = PTR_W'((int'(rr_ptr_q) + k) % NUM_CH);
      end else begin
        gnt_valid_s = gnt_valid_s;
      end
    end
  end

  // Mux out the winning channel's request fields.
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_len_s   = {LEN_W{1'b0}};
    sel_addr_s  = {ADDR_WIDTH{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx_s == PTR_W'(i)) begin
        sel_wr_s    = bus.ch_wr[i];
        sel_len_s   = bus.ch_len[i*LEN_W +: LEN_W];
        sel_addr_s  = bus.ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s = bus.ch_wdata[i*DATA_W +: DATA_W];
      end else begin
        sel_wr_s    = sel_wr_s;
      end
    end
  end

  assign stall_s = IO_STALL_EN & bus.io_buffer_full & ram_wr_q &
                   (state_q == S_WRITE) & in_io_window(ram_addr_q);

  // Next-state and datapath update for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    ch_d       = ch_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = ram_wr_q;
    ch_done_d  = {NUM_CH{1'b0}};
    case (state_q)
      S_IDLE: begin
        ram_wr_d = 1'b0;
        if (gnt_valid_s) begin
          rr_ptr_d   = PTR_W'((int'(gnt_idx_s) + 1) % NUM_CH);
          ch_d       = gnt_idx_s;
          len_d      = clamp_len(sel_len_s);
          ram_addr_d = sel_addr_s;
          rbuf_d     = {DATA_W{1'b0}};
          if (sel_wr_s) begin
            state_d    = S_WRITE;
            cnt_d      = LEN_W'(1);
            ram_wr_d   = 1'b1;
            ram_dout_d = sel_wdata_s[7:0];
            wdata_d    = sel_wdata_s >> 8;
          end else begin
            state_d    = S_READ;
            cnt_d      = {LEN_W{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        // cnt_q = k: byte k-1 is on ram_din because the RAM answers one cycle late.
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (cnt_q == LEN_W'(i + 1)) begin
            rbuf_d[8*i +: 8] = bus.ram_din;
          end else begin
            rbuf_d[8*i +: 8] = rbuf_q[8*i +: 8];
          end
        end
        if (cnt_q == len_q) begin
          state_d    = S_IDLE;
          rdata_d    = rbuf_d;
          ram_addr_d = {ADDR_WIDTH{1'b0}};
          cnt_d      = {LEN_W{1'b0}};
          for (int i = 0; i < NUM_CH; i++) begin
            ch_done_d[i] = (ch_q == PTR_W'(i));
          end
        end else begin
          ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
          cnt_d      = cnt_q + LEN_W'(1);
        end
      end
      S_WRITE: begin
        if (stall_s) begin
          state_d = S_WRITE;
        end else if (cnt_q < len_q) begin
          ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
          ram_dout_d = wdata_q[7:0];
          wdata_d    = wdata_q >> 8;
          cnt_d      = cnt_q + LEN_W'(1);
          ram_wr_d   = 1'b1;
        end else begin
          state_d    = S_IDLE;
          ram_wr_d   = 1'b0;
          ram_addr_d = {ADDR_WIDTH{1'b0}};
          ram_dout_d = 8'h00;
          cnt_d      = {LEN_W{1'b0}};
          for (int i = 0; i < NUM_CH; i++) begin
            ch_done_d[i] = (ch_q == PTR_W'(i));
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        ram_wr_d = 1'b0;
      end
    endcase
  end

  // State register; Sys_rdy low freezes everything.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= {PTR_W{1'b0}};
      ch_q       <= {PTR_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      cnt_q      <= {LEN_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      rbuf_q     <= {DATA_W{1'b0}};
      rdata_q    <= {DATA_W{1'b0}};
      ram_addr_q <= {ADDR_WIDTH{1'b0}};
      ram_dout_q <= 8'h00;
      ram_wr_q   <= 1'b0;
      ch_done_q  <= {NUM_CH{1'b0}};
    end else if (Sys_rdy) begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      ch_q       <= ch_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
      ch_done_q  <= ch_done_d;
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.ram_wr   = ram_wr_q & ~stall_s;
  assign bus.ch_done  = ch_done_q;
  assign bus.rdata    = rdata_q;
endmodule
